// File: rtl/filter_read_addr_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : filter_read_addr_gen_pkg
//  Description : Shared state encoding and filter-storage constants for the
//                filter read address generator and its completion detector.
//  Revision    : 1.0 - initial release
// ============================================================================
package filter_read_addr_gen_pkg;

    // Sequencer state encoding
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // Words of padded filter storage in use, packed from address 0
    localparam int c_filter_pad_length = 12;

    // Highest scratchpad address that can hold filter data; the downstream
    // completion detector compares against this value
    localparam int c_last_pad_addr = c_filter_pad_length - 1;

endpackage
`default_nettype wire

// File: rtl/filter_read_addr_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : filter_read_addr_gen_if
//  Description : Control and read-handshake bundle between the PE-side
//                controller (master) and the filter read address generator
//                (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface filter_read_addr_gen_if #(
    parameter int ADDR_WIDTH        = 8,
    parameter int FILTER_SIZE_WIDTH = 4,
    parameter int WINDOW_CNT_WIDTH  = 8
);
    logic                         start;
    logic [FILTER_SIZE_WIDTH-1:0] filter_size;
    logic [WINDOW_CNT_WIDTH-1:0]  num_windows;
    logic                         rd_ready;
    logic [ADDR_WIDTH-1:0]        read_addr;
    logic                         rd_valid;
    logic                         window_done;
    logic                         filter_done;
    logic                         done;
    logic                         busy;

    modport master (
        output start, filter_size, num_windows, rd_ready,
        input  read_addr, rd_valid, window_done, filter_done, done, busy
    );

    modport slave (
        input  start, filter_size, num_windows, rd_ready,
        output read_addr, rd_valid, window_done, filter_done, done, busy
    );
endinterface
`default_nettype wire

// File: rtl/filter_window_counter.sv
`default_nettype none
// ============================================================================
//  Module      : filter_window_counter
//  Description : Word-offset and window-pass counters for one filter, with
//                last-word / last-window flags used by the sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module filter_window_counter
    import filter_read_addr_gen_pkg::*;
#(
    parameter int FILTER_SIZE_WIDTH = 4,
    parameter int WINDOW_CNT_WIDTH  = 8
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic                         i_clear,
    input  wire logic                         i_advance,
    input  wire logic [FILTER_SIZE_WIDTH-1:0] i_fs,
    input  wire logic [WINDOW_CNT_WIDTH-1:0]  i_nw,
    output logic      [FILTER_SIZE_WIDTH-1:0] o_offset,
    output logic                              o_offset_last,
    output logic                              o_win_last
);

    localparam logic [FILTER_SIZE_WIDTH-1:0] c_fs_one = 1;
    localparam logic [WINDOW_CNT_WIDTH-1:0]  c_nw_one = 1;

    logic [FILTER_SIZE_WIDTH-1:0] r_offset;
    logic [WINDOW_CNT_WIDTH-1:0]  r_win;

    assign o_offset      = r_offset;
    assign o_offset_last = (r_offset == (i_fs - c_fs_one));
    assign o_win_last    = (r_win == (i_nw - c_nw_one));

    // Offset counts words within a pass; window counts passes and both wrap
    // together when the last word of the last pass is consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_offset <= '0;
            r_win    <= '0;
        end else if (i_clear) begin
            r_offset <= '0;
            r_win    <= '0;
        end else if (i_advance) begin
            if (!o_offset_last) begin
                r_offset <= r_offset + c_fs_one;
            end else begin
                r_offset <= '0;
                r_win    <= o_win_last ? '0 : (r_win + c_nw_one);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/filter_read_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : filter_read_addr_gen
//  Description : Walks every packed filter in the padded filter scratchpad
//                once per input window, handshaking each address with the PE.
//  Revision    : 1.0 - initial release
// ============================================================================
module filter_read_addr_gen
    import filter_read_addr_gen_pkg::*;
#(
    parameter int ADDR_WIDTH        = 8,
    parameter int FILTER_SIZE_WIDTH = 4,
    parameter int WINDOW_CNT_WIDTH  = 8,
    parameter int FILTER_PAD_LENGTH = c_filter_pad_length
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    filter_read_addr_gen_if.slave     bus
);

    // Extended width so base + 2*fs can never wrap in the fit check
    localparam int c_ext_w = ADDR_WIDTH + 2;
    localparam logic [c_ext_w-1:0]    c_pad_len_ext = c_ext_w'(FILTER_PAD_LENGTH);
    localparam logic [ADDR_WIDTH-1:0] c_addr_one    = 1;

    logic [1:0]                   r_state;
    logic [FILTER_SIZE_WIDTH-1:0] r_fs;
    logic [WINDOW_CNT_WIDTH-1:0]  r_nw;
    logic [ADDR_WIDTH-1:0]        r_base;
    logic [ADDR_WIDTH-1:0]        r_read_addr;
    logic                         r_window_done;
    logic                         r_filter_done;

    logic                         w_cfg_ok;
    logic                         w_start_ok;
    logic                         w_beat;
    logic [FILTER_SIZE_WIDTH-1:0] w_offset;
    logic                         w_offset_last;
    logic                         w_win_last;
    logic [ADDR_WIDTH-1:0]        w_addr_inc;
    logic [ADDR_WIDTH-1:0]        w_next_base;
    logic [c_ext_w-1:0]           w_fs_ext;
    logic [c_ext_w-1:0]           w_next_end_ext;
    logic                         w_next_fits;
    logic [31:0]                  w_size_wide;

    // A start is only honoured outside RUN and with a usable configuration
    assign w_size_wide = 32'(bus.filter_size);
    assign w_cfg_ok    = (bus.filter_size != '0) &&
                         (w_size_wide <= 32'(FILTER_PAD_LENGTH)) &&
                         (bus.num_windows != '0);
    assign w_start_ok  = bus.start && (r_state != c_st_run) && w_cfg_ok;
    assign w_beat      = (r_state == c_st_run) && bus.rd_ready;

    // Next address within a pass, and whether another whole filter fits
    assign w_addr_inc     = r_base + ADDR_WIDTH'(w_offset) + c_addr_one;
    assign w_next_base    = r_base + ADDR_WIDTH'(r_fs);
    assign w_fs_ext       = c_ext_w'(r_fs);
    assign w_next_end_ext = c_ext_w'(r_base) + w_fs_ext + w_fs_ext;
    assign w_next_fits    = (w_next_end_ext <= c_pad_len_ext);

    filter_window_counter #(
        .FILTER_SIZE_WIDTH (FILTER_SIZE_WIDTH),
        .WINDOW_CNT_WIDTH  (WINDOW_CNT_WIDTH)
    ) u_counter (
        .clk           (clk),
        .rst           (rst),
        .i_clear       (w_start_ok),
        .i_advance     (w_beat),
        .i_fs          (r_fs),
        .i_nw          (r_nw),
        .o_offset      (w_offset),
        .o_offset_last (w_offset_last),
        .o_win_last    (w_win_last)
    );

    // Sequencer: state, latched configuration, filter base, registered
    // address and the one-cycle completion pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_fs          <= '0;
            r_nw          <= '0;
            r_base        <= '0;
            r_read_addr   <= '0;
            r_window_done <= 1'b0;
            r_filter_done <= 1'b0;
        end else begin
            r_window_done <= 1'b0;
            r_filter_done <= 1'b0;
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (w_start_ok) begin
                        r_state     <= c_st_run;
                        r_fs        <= bus.filter_size;
                        r_nw        <= bus.num_windows;
                        r_base      <= '0;
                        r_read_addr <= '0;
                    end
                end
                c_st_run: begin
                    if (bus.rd_ready) begin
                        if (!w_offset_last) begin
                            r_read_addr <= w_addr_inc;
                        end else begin
                            r_window_done <= 1'b1;
                            if (!w_win_last) begin
                                r_read_addr <= r_base;
                            end else begin
                                r_filter_done <= 1'b1;
                                if (w_next_fits) begin
                                    r_base      <= w_next_base;
                                    r_read_addr <= w_next_base;
                                end else begin
                                    // Final address is held for the detector
                                    r_state <= c_st_done;
                                end
                            end
                        end
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign bus.read_addr   = r_read_addr;
    assign bus.rd_valid    = (r_state == c_st_run);
    assign bus.busy        = (r_state == c_st_run);
    assign bus.done        = (r_state == c_st_done);
    assign bus.window_done = r_window_done;
    assign bus.filter_done = r_filter_done;

endmodule
`default_nettype wire

// File: tb/tb_filter_read_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_filter_read_addr_gen
//  Description : Directed self-checking bench for filter_read_addr_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_filter_read_addr_gen;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   exp_q[$];

    filter_read_addr_gen_if #(
        .ADDR_WIDTH        (8),
        .FILTER_SIZE_WIDTH (4),
        .WINDOW_CNT_WIDTH  (8)
    ) bus ();

    filter_read_addr_gen #(
        .ADDR_WIDTH        (8),
        .FILTER_SIZE_WIDTH (4),
        .WINDOW_CNT_WIDTH  (8),
        .FILTER_PAD_LENGTH (12)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int fs, input int nw);
        bus.start       = 1'b1;
        bus.filter_size = 4'(fs);
        bus.num_windows = 8'(nw);
        tick();
        bus.start       = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"},  32'(bus.read_addr),   0);
        chk({tag, "_valid"}, 32'(bus.rd_valid),    0);
        chk({tag, "_wd"},    32'(bus.window_done), 0);
        chk({tag, "_fd"},    32'(bus.filter_done), 0);
        chk({tag, "_done"},  32'(bus.done),        0);
        chk({tag, "_busy"},  32'(bus.busy),        0);
    endtask

    // Walks exp_q with rd_ready high, optionally stalling 3 cycles at beat
    // stall_k and pulsing an ignored start at beat inject_k
    task automatic run_seq(input string tag, input int fs, input int nw,
                           input int stall_k, input int inject_k);
        int per_filter;
        per_filter = fs * nw;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k == 0) begin
                chk({tag, "_done_clr"}, 32'(bus.done), 0);
                chk({tag, "_busy"},     32'(bus.busy), 1);
            end
            chk({tag, "_addr"},  32'(bus.read_addr), 32'(exp_q[k]));
            chk({tag, "_valid"}, 32'(bus.rd_valid),  1);
            if (k == stall_k) begin
                bus.rd_ready = 1'b0;
                repeat (3) begin
                    tick();
                    chk({tag, "_stall_addr"}, 32'(bus.read_addr), 32'(exp_q[k]));
                    chk({tag, "_stall_wd"},   32'(bus.window_done), 0);
                end
                bus.rd_ready = 1'b1;
            end
            if (k == inject_k) begin
                bus.start       = 1'b1;
                bus.filter_size = 4'd1;
                bus.num_windows = 8'd1;
            end
            tick();
            bus.start = 1'b0;
            chk({tag, "_wd"}, 32'(bus.window_done), 32'((k % fs) == fs - 1));
            chk({tag, "_fd"}, 32'(bus.filter_done), 32'((k % per_filter) == per_filter - 1));
        end
        chk({tag, "_end_done"},  32'(bus.done),      1);
        chk({tag, "_end_busy"},  32'(bus.busy),      0);
        chk({tag, "_end_valid"}, 32'(bus.rd_valid),  0);
        chk({tag, "_end_addr"},  32'(bus.read_addr), 32'(exp_q[exp_q.size()-1]));
        tick();
        chk({tag, "_hold_addr"}, 32'(bus.read_addr),   32'(exp_q[exp_q.size()-1]));
        chk({tag, "_hold_wd"},   32'(bus.window_done), 0);
        chk({tag, "_hold_fd"},   32'(bus.filter_done), 0);
        chk({tag, "_hold_done"}, 32'(bus.done),        1);
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.filter_size = '0;
        bus.num_windows = '0;
        bus.rd_ready    = 1'b1;
        #1;
        chk_all_zero("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Invalid configurations leave the block idle
        do_start(0, 1);
        chk("fs0_valid", 32'(bus.rd_valid), 0);
        chk("fs0_busy",  32'(bus.busy),     0);
        do_start(13, 1);
        chk("fs13_valid", 32'(bus.rd_valid), 0);
        chk("fs13_busy",  32'(bus.busy),     0);
        do_start(4, 0);
        chk("nw0_valid", 32'(bus.rd_valid), 0);
        chk("nw0_busy",  32'(bus.busy),     0);
        chk("nw0_done",  32'(bus.done),     0);

        // fs=4 nw=2, full throughput, start pulsed mid-run is ignored
        exp_q = '{0,1,2,3,0,1,2,3,4,5,6,7,4,5,6,7,8,9,10,11,8,9,10,11};
        do_start(4, 2);
        run_seq("t1", 4, 2, -1, 5);

        // Same configuration restarted from DONE, stalled at address 5
        do_start(4, 2);
        run_seq("t2", 4, 2, 9, -1);

        // fs=5 nw=1 stops at 9; words 10 and 11 never addressed
        exp_q = '{0,1,2,3,4,5,6,7,8,9};
        do_start(5, 1);
        run_seq("t3", 5, 1, -1, -1);

        // Asynchronous reset while address 6 is presented
        do_start(4, 2);
        for (int k = 0; k < 10; k++) tick();
        chk("t5_pre_addr", 32'(bus.read_addr), 6);
        rst = 1'b1;
        #1;
        chk_all_zero("t5_rst");
        tick();
        rst = 1'b0;
        tick();
        exp_q = '{0,1,2,3,4,5,6,7,8,9,10,11};
        do_start(4, 1);
        run_seq("t5", 4, 1, -1, -1);

        // Restart from DONE with fs=3 nw=1
        do_start(3, 1);
        run_seq("t6", 3, 1, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/filter_read_addr_gen.md
Name: filter_read_addr_gen

Overview:
Sequences read addresses over the padded filter scratchpad for the PE datapath. It walks each filter of `filter_size` words once per input window, for `num_windows` windows, then advances to the next packed filter. It stops when no further whole filter fits in FILTER_PAD_LENGTH words. Its `read_addr` output feeds the scratchpad read port and the downstream filter completion detector. A valid/ready handshake with the PE stalls it.

Parameters:
- ADDR_WIDTH, 8, scratchpad address width.
- FILTER_SIZE_WIDTH, 4, width of `filter_size`.
- WINDOW_CNT_WIDTH, 8, width of `num_windows`.
- FILTER_PAD_LENGTH, 12, words of filter storage in use (filters packed from address 0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a sequence.
- filter_size  in  FILTER_SIZE_WIDTH  words per filter; sampled on accepted start.
- num_windows  in  WINDOW_CNT_WIDTH  passes per filter; sampled on accepted start.
- rd_ready  in  1  PE accepts the current address.
- read_addr  out  ADDR_WIDTH  current scratchpad read address (registered).
- rd_valid  out  1  `read_addr` is valid.
- window_done  out  1  one-cycle pulse: last word of a window pass accepted.
- filter_done  out  1  one-cycle pulse: last word of the last window of a filter accepted.
- done  out  1  level; high while in DONE.
- busy  out  1  high while in RUN.

Behaviour:
- **Reset (async):** state=IDLE. `read_addr`, `rd_valid`, `window_done`, `filter_done`, `done`, `busy` and all internal counters are 0. Reset mid-RUN aborts immediately. No pulse is emitted.
- **States:** IDLE, RUN, DONE.
- **Accepting start:** start is accepted only in IDLE or DONE. It is ignored in RUN. It is also ignored (state unchanged) if `filter_size`==0, `filter_size` > FILTER_PAD_LENGTH, or `num_windows`==0.
- **On an accepted start:**
  - latch `filter_size` to fs and `num_windows` to nw;
  - base=0, offset=0, win=0;
  - next cycle: RUN, `rd_valid`=1, `read_addr`=0, `done`=0, `busy`=1.
- **Address arithmetic:** `read_addr` = base + offset, computed in ADDR_WIDTH bits. base+fs is evaluated with one extra bit so it cannot wrap.
- **Handshake:** the address advances only on a cycle with `rd_valid`&`rd_ready`. While `rd_ready`=0, `read_addr` and all counters hold. There is no combinational path from `rd_ready` to `read_addr`.
- **On an accepted beat in RUN:**
  - offset<fs-1: offset+1.
  - offset==fs-1 and win<nw-1: offset=0, win+1, `window_done`=1 next cycle.
  - offset==fs-1 and win==nw-1 and base+2*fs ≤ FILTER_PAD_LENGTH: base+=fs, offset=0, win=0, `window_done`=1 and `filter_done`=1 next cycle.
  - otherwise (last filter): go to DONE; `window_done`=1 and `filter_done`=1 next cycle.
- **DONE:**
  - `rd_valid`=0, `busy`=0, `done`=1.
  - `read_addr` holds the final address, so the downstream detector keeps seeing it.
  - A new valid start restarts the sequence.
- **Throughput:** one address per cycle with `rd_ready` held high; zero bubbles between windows and between filters.
- **Pulses:** `window_done` and `filter_done` are registered, one cycle wide, and appear the cycle after the accepting beat.
- Words beyond nf·fs are never addressed, where nf = floor(FILTER_PAD_LENGTH/fs).

Decomposition:
- Shared package: state encoding (IDLE/RUN/DONE) and a localparam for the FILTER_PAD_LENGTH-1 last-address constant. The completion detector reuses this constant.
- One natural sub-module: `filter_window_counter`. It holds the offset/win counters with wrap flags. The FSM and base/address logic stay in the top.

Test Plan:
1. fs=4, nw=2, `rd_ready`=1 -> addresses 0,1,2,3,0,1,2,3,4..7,4..7,8..11,8..11 on 24 consecutive cycles; 6 `window_done` pulses, 3 `filter_done` pulses; `done` rises the cycle after address 11 is accepted; `read_addr` holds 11.
2. Same config, `rd_ready` low for 3 cycles while `read_addr`=5 -> `read_addr` stays 5 for 4 cycles; the sequence then resumes at 6; total still 24 accepted beats.
3. fs=5, nw=1 -> addresses 0..9 only; DONE with `read_addr`=9; addresses 10 and 11 are never issued.
4. Start with fs=0, then with fs=13, then with nw=0 -> remains IDLE, `rd_valid`=0, `busy`=0. Start pulsed during RUN -> no effect on the sequence.
5. Assert `rst` while `read_addr`=6 in RUN -> same-cycle async clear; all outputs 0, state IDLE. A following start with fs=4, nw=1 begins at address 0.
6. From DONE, start with fs=3, nw=1 -> `done` clears; addresses 0..11 are issued; `done` rises again.
